ysyx_22050550_wbu_retire: RTL
=============================

// Module: ysyx_22050550_wbu_retire
// PURPOSE
//  Buffered, parametrised writeback/retire stage after LSU. Accepts LS->WB ops through a
//  valid/ready handshake into a DEPTH-entry in-order retire FIFO.
//  Retires one op per cycle to regfile, CSR file and difftest/commit port.
//  CSR/ecall/mret ops are serialised through a 2-cycle read-then-write FSM.
//  Adds csrrc, rs1=x0 write suppression, trap redirect and flush.
// PARAMETERS
//  XLEN   64  datapath width (pc, data, CSR values)
//  DEPTH  4   retire FIFO entries; power of 2, >=2
// PORTS
//  clock        in   1     clock
//  reset        in   1     async, active-high
//  in_valid     in   1     LS->WB op valid
//  in_ready     out  1     FIFO can accept; equals (count!=DEPTH)
//  in_pc        in   XLEN  op pc
//  in_inst      in   32    op instruction
//  in_rs1addr   in   5     rs1 index (CSR write suppression)
//  in_waddr     in   5     rd index
//  in_wen       in   1     rd write request
//  in_alures    in   XLEN  ALU result; rs1 value for CSR ops
//  in_lsures    in   XLEN  load result
//  in_flags     in   4     {mret,ecall,csr,read}
//  in_nextpc    in   XLEN  next pc, for difftest
//  flush        in   1     drop all buffered ops
//  stall        in   1     hold head (no retire this cycle)
//  csr_mepc/mcause/mtvec/mstatus/mie/mip  in  XLEN each  current CSR values
//  wb_mepc/mcause/mtvec/mstatus/mie/mip   out XLEN each  CSR write data
//  wb_csren     out  8     bit0 mepc,1 mcause,2 mtvec,3 mstatus,4 mie,5 mip; 7:6 = 0
//  rf_wen       out  1     regfile write strobe
//  rf_waddr     out  5     regfile write index
//  rf_wdata     out  XLEN  regfile write data
//  cm_valid     out  1     one-cycle pulse per retired op
//  cm_pc, cm_nextpc  out XLEN   retired op pc / next pc
//  cm_inst      out  32    retired op instruction
//  trap_valid   out  1     redirect pulse (ecall/mret retire)
//  trap_pc      out  XLEN  mtvec for ecall, mepc for mret
// BEHAVIOUR
//  Reset: count=0, pointers=0, state=S_RUN, csr_old=0. All outputs are 0 except in_ready=1.
//  Push on in_valid&in_ready. Earliest retire is the cycle after the push.
//  Outputs are combinational from FIFO head and state; all 0 while count==0.
//  Full: in_ready=0, no push. Pointers wrap mod DEPTH.
//  Push and pop in the same cycle leave count unchanged.
//  S_RUN, plain head, !stall: retire in 1 cycle, pop.
//   rf_wen = wen & (waddr!=0).
//   rf_wdata = read ? lsures : alures.
//  S_RUN, CSR/ecall/mret head, !stall: latch csr_old = CSR selected by inst[31:20]
//   (0 if the index is unmapped), go to S_CSR. No retire and no pop this cycle.
//  S_CSR, !stall: drive CSR writes and rf write of csr_old, pulse cm_valid, pop, return to S_RUN.
//  CSR index map: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip.
//  func3 001 csrrw: new = alures.
//   010 csrrs: new = old|alures.  011 csrrc: new = old&~alures.
//   csrrs/csrrc with rs1addr==0 -> csren=0.
//  ecall: csren=0x0B, mepc=pc, mcause=11, mstatus: MPIE(7)<=MIE(3), MIE<=0.
//   trap_pc=csr_mtvec.
//  mret: csren=0x08, mstatus: MIE<=MPIE, MPIE<=1. trap_pc=csr_mepc.
//  On trap retire the FIFO is also cleared (younger ops discarded).
//  stall in either state holds state and head. Outputs stay 0 while stalled.
//  flush has highest priority: count/pointers cleared, state=S_RUN.
//   Same-cycle push is dropped and no retire occurs.
//  Unknown flag combos: csr > ecall > mret priority.
// CONFIGURATION
//  YSYX_22050550_WB_CSRIMM_EN defined: func3 101/110/111 (csrrwi/csrrsi/csrrci).
//   These use zimm = zero-extended inst[19:15] in place of alures.
//   For si/ci, zimm==0 suppresses the write.
//  YSYX_22050550_WB_CSRIMM_EN undefined: those func3 values give csren=0.
//   rd still receives csr_old.
// TESTING
//  T1 reset mid-traffic with 3 ops queued -> next cycle count=0, cm_valid=0, in_ready=1.
//  T2 push 5 plain ops, stall=1, DEPTH=4 -> in_ready=0 after 4 pushes.
//   Release stall -> 4 in-order cm_valid pulses; rd x0 never writes.
//  T3 csrrs mstatus(0x300), alures=0x8, csr_mstatus=0x1800 -> 2 cycles later
//   wb_mstatus=0x1808, csren=0x08, rf_wdata=0x1800.
//  T4 csrrc with rs1addr=0 -> csren=0, rd gets old value, 2-cycle retire.
//  T5 ecall pc=0x80000010, mstatus=0x8, mtvec=0x80000100 -> wb_mepc=0x80000010,
//   wb_mcause=0xB, wb_mstatus=0x80, trap_pc=0x80000100, FIFO empty after.
//  T6 flush with simultaneous push while in S_CSR -> no retire, count=0, state S_RUN.

Source files
------------

// File: rtl/ysyx_22050550_wbu_retire_if.sv
// LS->WB op bus for the buffered writeback/retire stage.
// The LSU side drives the op fields and valid (master); the WBU side
// returns ready (slave).
interface ysyx_22050550_wbu_retire_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic [4:0]      in_rs1addr;
    logic [4:0]      in_waddr;
    logic            in_wen;
    logic [XLEN-1:0] in_alures;
    logic [XLEN-1:0] in_lsures;
    logic [3:0]      in_flags;     // {mret, ecall, csr, read}
    logic [XLEN-1:0] in_nextpc;

    modport master (
        output in_valid, in_pc, in_inst, in_rs1addr, in_waddr, in_wen,
               in_alures, in_lsures, in_flags, in_nextpc,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_rs1addr, in_waddr, in_wen,
               in_alures, in_lsures, in_flags, in_nextpc,
        output in_ready
    );
endinterface

// File: rtl/ysyx_22050550_wbu_retire.sv
// Buffered writeback/retire stage.
// Ops from the LSU enter a DEPTH-entry in-order FIFO and retire one per
// cycle to the regfile, the CSR file and the commit port. CSR, ecall and
// mret ops take two cycles: the first latches the old CSR value, the
// second performs all writes. ecall/mret also redirect the pc and discard
// every younger buffered op.
// Optional feature: define YSYX_22050550_WB_CSRIMM_EN to enable the
// immediate CSR forms (csrrwi/csrrsi/csrrci).
module ysyx_22050550_wbu_retire #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    ysyx_22050550_wbu_retire_if.slave   ls_wb,
    input  logic                        flush,
    input  logic                        stall,
    input  logic [XLEN-1:0]             csr_mepc,
    input  logic [XLEN-1:0]             csr_mcause,
    input  logic [XLEN-1:0]             csr_mtvec,
    input  logic [XLEN-1:0]             csr_mstatus,
    input  logic [XLEN-1:0]             csr_mie,
    input  logic [XLEN-1:0]             csr_mip,
    output logic [XLEN-1:0]             wb_mepc,
    output logic [XLEN-1:0]             wb_mcause,
    output logic [XLEN-1:0]             wb_mtvec,
    output logic [XLEN-1:0]             wb_mstatus,
    output logic [XLEN-1:0]             wb_mie,
    output logic [XLEN-1:0]             wb_mip,
    output logic [7:0]                  wb_csren,
    output logic                        rf_wen,
    output logic [4:0]                  rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic                        cm_valid,
    output logic [XLEN-1:0]             cm_pc,
    output logic [XLEN-1:0]             cm_nextpc,
    output logic [31:0]                 cm_inst,
    output logic                        trap_valid,
    output logic [XLEN-1:0]             trap_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_RUN = 1'b0;
    localparam logic [0:0] S_CSR = 1'b1;

    // One buffered LS->WB op.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rs1addr;
        logic [4:0]      waddr;
        logic            wen;
        logic [XLEN-1:0] alures;
        logic [XLEN-1:0] lsures;
        logic [3:0]      flags;
        logic [XLEN-1:0] nextpc;
    } op_t;

    op_t             r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [0:0]      r_state;
    logic [XLEN-1:0] r_csr_old;

    op_t             w_in;
    op_t             w_head;
    logic            w_push;
    logic            w_active;
    logic            w_is_csr;
    logic            w_is_ecall;
    logic            w_is_mret;
    logic            w_special;
    logic            w_trap;
    logic            w_retire;
    logic            w_latch;
    logic [11:0]     w_csr_idx;
    logic [2:0]      w_func3;
    logic [XLEN-1:0] w_csr_sel;
    logic [XLEN-1:0] w_csr_new;
    logic            w_csr_we;

    assign ls_wb.in_ready = (r_count != CW'(DEPTH));

    // Pack the incoming op and expose the FIFO head.
    always_comb begin
        w_in.pc      = ls_wb.in_pc;
        w_in.inst    = ls_wb.in_inst;
        w_in.rs1addr = ls_wb.in_rs1addr;
        w_in.waddr   = ls_wb.in_waddr;
        w_in.wen     = ls_wb.in_wen;
        w_in.alures  = ls_wb.in_alures;
        w_in.lsures  = ls_wb.in_lsures;
        w_in.flags   = ls_wb.in_flags;
        w_in.nextpc  = ls_wb.in_nextpc;
        w_head       = r_mem[r_rptr];
    end

    // Head classification; csr beats ecall beats mret on odd flag combos.
    assign w_push     = ls_wb.in_valid & ls_wb.in_ready & ~flush;
    assign w_active   = (r_count != '0) & ~stall & ~flush;
    assign w_is_csr   = w_head.flags[1];
    assign w_is_ecall = ~w_head.flags[1] & w_head.flags[2];
    assign w_is_mret  = ~w_head.flags[1] & ~w_head.flags[2] & w_head.flags[3];
    assign w_special  = w_is_csr | w_is_ecall | w_is_mret;
    assign w_trap     = w_is_ecall | w_is_mret;
    assign w_retire   = w_active & ((r_state == S_CSR) | ~w_special);
    assign w_latch    = w_active & (r_state == S_RUN) & w_special;
    assign w_csr_idx  = w_head.inst[31:20];
    assign w_func3    = w_head.inst[14:12];

    // Select the current value of the CSR addressed by the head op.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        w_csr_sel = '0;
        case (w_csr_idx)
            12'h300: w_csr_sel = csr_mstatus;
            12'h304: w_csr_sel = csr_mie;
            12'h305: w_csr_sel = csr_mtvec;
            12'h341: w_csr_sel = csr_mepc;
            12'h342: w_csr_sel = csr_mcause;
            12'h344: w_csr_sel = csr_mip;
            default: w_csr_sel = '0;
        endcase
    end

    // Compute the new CSR value and whether the op really writes it.
    always_comb begin
        w_csr_new = '0;
        w_csr_we  = 1'b0;
        case (w_func3)
            3'b001: begin
                w_csr_new = w_head.alures;
                w_csr_we  = 1'b1;
            end
            3'b010: begin
                w_csr_new = r_csr_old | w_head.alures;
                w_csr_we  = (w_head.rs1addr != 5'd0);
            end
            3'b011: begin
                w_csr_new = r_csr_old & ~w_head.alures;
                w_csr_we  = (w_head.rs1addr != 5'd0);
            end
`ifdef YSYX_22050550_WB_CSRIMM_EN
            3'b101: begin
                w_csr_new = {{(XLEN-5){1'b0}}, w_head.inst[19:15]};
                w_csr_we  = 1'b1;
            end
            3'b110: begin
                w_csr_new = r_csr_old | {{(XLEN-5){1'b0}}, w_head.inst[19:15]};
                w_csr_we  = (w_head.inst[19:15] != 5'd0);
            end
            3'b111: begin
                w_csr_new = r_csr_old & ~{{(XLEN-5){1'b0}}, w_head.inst[19:15]};
                w_csr_we  = (w_head.inst[19:15] != 5'd0);
            end
`endif
            default: begin
                w_csr_new = '0;
                w_csr_we  = 1'b0;
            end
        endcase
    end

    // Drive regfile, CSR, commit and redirect outputs for the retiring op.
    always_comb begin
        cm_valid   = 1'b0;
        cm_pc      = '0;
        cm_nextpc  = '0;
        cm_inst    = '0;
        rf_wen     = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        wb_mepc    = '0;
        wb_mcause  = '0;
        wb_mtvec   = '0;
        wb_mstatus = '0;
        wb_mie     = '0;
        wb_mip     = '0;
        wb_csren   = '0;
        trap_valid = 1'b0;
        trap_pc    = '0;
        if (w_retire) begin
            cm_valid  = 1'b1;
            cm_pc     = w_head.pc;
            cm_nextpc = w_head.nextpc;
            cm_inst   = w_head.inst;
            rf_wen    = w_head.wen & (w_head.waddr != 5'd0);
            rf_waddr  = w_head.waddr;
            if (w_special) begin
                rf_wdata = r_csr_old;
            end else begin
                rf_wdata = w_head.flags[0] ? w_head.lsures : w_head.alures;
            end
            if (w_is_csr) begin
                if (w_csr_we) begin
                    case (w_csr_idx)
                        12'h300: begin wb_mstatus = w_csr_new; wb_csren[3] = 1'b1; end
                        12'h304: begin wb_mie     = w_csr_new; wb_csren[4] = 1'b1; end
                        12'h305: begin wb_mtvec   = w_csr_new; wb_csren[2] = 1'b1; end
                        12'h341: begin wb_mepc    = w_csr_new; wb_csren[0] = 1'b1; end
                        12'h342: begin wb_mcause  = w_csr_new; wb_csren[1] = 1'b1; end
                        12'h344: begin wb_mip     = w_csr_new; wb_csren[5] = 1'b1; end
                        default: wb_csren = '0;
                    endcase
                end
            end else if (w_is_ecall) begin
                wb_csren      = 8'h0B;
                wb_mepc       = w_head.pc;
                wb_mcause     = XLEN'(11);
                wb_mstatus    = csr_mstatus;
                wb_mstatus[7] = csr_mstatus[3];
                wb_mstatus[3] = 1'b0;
                trap_valid    = 1'b1;
                trap_pc       = csr_mtvec;
            end else if (w_is_mret) begin
                wb_csren      = 8'h08;
                wb_mstatus    = csr_mstatus;
                wb_mstatus[3] = csr_mstatus[7];
                wb_mstatus[7] = 1'b1;
                trap_valid    = 1'b1;
                trap_pc       = csr_mepc;
            end
        end
    end

    // FIFO storage: written on accepted push only.
    always_ff @(posedge clock) begin
        // NOTE: the op array is not reset; r_count alone marks which entries are valid.
        if (w_push) begin
            r_mem[r_wptr] <= w_in;
        end
    end

    // Pointers, occupancy, retire FSM and latched old CSR value.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_state   <= S_RUN;
            r_csr_old <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= S_RUN;
        end else if (w_retire && w_trap) begin
            // Redirect: every younger op, including a same-cycle push, is dropped.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= S_RUN;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_retire) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_latch) begin
                r_state   <= S_CSR;
                r_csr_old <= w_csr_sel;
            end else if (w_retire) begin
                r_state <= S_RUN;
            end
        end
    end

endmodule
